// File: rtl/conv2d_stream_engine.sv
// Streaming 3x3 valid-padding convolution (stride 1) over an IMG_W x IMG_H raster frame.
// Define CONV_SIGNED_EN for two's-complement pixels/weights; default build is unsigned.
module conv2d_stream_engine #(
  parameter int IFM_W = 16,
  parameter int WGT_W = 16,
  parameter int IMG_W = 14,
  parameter int IMG_H = 14,
  parameter int ACC_W = IFM_W + WGT_W + 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IFM_W-1:0] In_IFM,
  input  logic [WGT_W-1:0] In_Weight,
  output logic             out_valid,
  output logic [ACC_W-1:0] Out_OFM,
  output logic             frame_done,
  output logic             busy
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PW = IFM_W + WGT_W;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [3:0]       beat;

  logic [IFM_W-1:0] lb0 [IMG_W];
  logic [IFM_W-1:0] lb1 [IMG_W];
  logic [IFM_W-1:0] win [3][2];
  logic [WGT_W-1:0] weight_buf [9];

  logic [IFM_W-1:0] new_col [3];
  logic [IFM_W-1:0] px [9];
  logic [WGT_W-1:0] wv [9];
  logic [ACC_W-1:0] sum;
`ifdef CONV_SIGNED_EN
  logic signed [PW-1:0] prod;
`else
  logic [PW-1:0]        prod;
`endif

  logic last_col;
  logic last_px;
  logic emit;

  assign last_col = (col == COL_LAST);
  assign last_px  = last_col && (row == ROW_LAST);
  assign emit     = in_valid && (row >= RW'(2)) && (col >= CW'(2));

  // The window's right column is the pixel arriving now, so the sum covers it directly.
  // A weight written this beat is bypassed in, which matters only for very small frames.
  always_comb begin
    new_col[0] = lb1[col];
    new_col[1] = lb0[col];
    new_col[2] = In_IFM;
    for (int i = 0; i < 3; i++) begin
      px[3*i]   = win[i][0];
      px[3*i+1] = win[i][1];
      px[3*i+2] = new_col[i];
    end
    for (int k = 0; k < 9; k++) begin
      wv[k] = (beat == 4'(k)) ? In_Weight : weight_buf[k];
    end
    prod = '0;
    sum  = '0;
    for (int k = 0; k < 9; k++) begin
`ifdef CONV_SIGNED_EN
      prod = $signed(px[k]) * $signed(wv[k]);
      sum  = sum + {{(ACC_W-PW){prod[PW-1]}}, prod};
`else
      prod = PW'(px[k]) * PW'(wv[k]);
      sum  = sum + {{(ACC_W-PW){1'b0}}, prod};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      col        <= '0;
      row        <= '0;
      beat       <= '0;
      out_valid  <= 1'b0;
      Out_OFM    <= '0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= emit;
      Out_OFM    <= emit ? sum : '0;
      frame_done <= in_valid && last_px;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (in_valid && last_px) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (in_valid) begin
        if (last_px) begin
          col  <= '0;
          row  <= '0;
          beat <= '0;
        end else begin
          if (last_col) begin
            col <= '0;
            row <= row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
          if (beat != 4'd9) beat <= beat + 4'd1;
        end
      end
    end
  end

  // Line buffers are addressed by column, so each entry holds the pixel one/two rows above.
  always_ff @(posedge clk) begin
    if (!rst && in_valid) begin
      lb1[col] <= lb0[col];
      lb0[col] <= In_IFM;
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= new_col[i];
      end
      if (beat < 4'd9) weight_buf[beat] <= In_Weight;
    end
  end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Self-checking bench for conv2d_stream_engine: directed and random frames against a
// direct-convolution reference model built from whole-frame pixel arrays.
module tb_conv2d_stream_engine;

  localparam int IFM_W = 16;
  localparam int WGT_W = 16;
  localparam int IMG_W = 14;
  localparam int IMG_H = 14;
  localparam int ACC_W = IFM_W + WGT_W + 4;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NOUT  = (IMG_W - 2) * (IMG_H - 2);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [IFM_W-1:0] in_ifm;
  logic [WGT_W-1:0] in_wgt;
  logic             out_valid;
  logic [ACC_W-1:0] out_ofm;
  logic             frame_done;
  logic             busy;

  always #5 clk = ~clk;

  conv2d_stream_engine #(
    .IFM_W(IFM_W), .WGT_W(WGT_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .In_IFM(in_ifm), .In_Weight(in_wgt),
    .out_valid(out_valid), .Out_OFM(out_ofm), .frame_done(frame_done), .busy(busy)
  );

  int               vectors = 0;
  int               miscompares = 0;
  int               idx = 0;
  int               cyc = 0;
  int               frame_out = 0;
  logic [IFM_W-1:0] pix [IMG_H][IMG_W];
  logic [WGT_W-1:0] wts [9];
  logic [ACC_W-1:0] first_out;
  logic [ACC_W-1:0] last_out;

  function automatic longint extPx(logic [IFM_W-1:0] p);
`ifdef CONV_SIGNED_EN
    return longint'($signed(p));
`else
    return longint'(p);
`endif
  endfunction

  function automatic longint extW(logic [WGT_W-1:0] w);
`ifdef CONV_SIGNED_EN
    return longint'($signed(w));
`else
    return longint'(w);
`endif
  endfunction

  function automatic logic [ACC_W-1:0] refConv(int r, int c);
    longint s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += extPx(pix[r-2+i][c-2+j]) * extW(wts[3*i+j]);
    return s[ACC_W-1:0];
  endfunction

  task automatic check(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input logic ev, input logic [ACC_W-1:0] eo, input logic ed, input logic eb);
    check("out_valid", ACC_W'(out_valid), ACC_W'(ev));
    check("Out_OFM", out_ofm, eo);
    check("frame_done", ACC_W'(frame_done), ACC_W'(ed));
    check("busy", ACC_W'(busy), ACC_W'(eb));
    if (out_valid === 1'b1) begin
      frame_out++;
      if (frame_out == 1) first_out = out_ofm;
      last_out = out_ofm;
    end
    if (ed) begin
      check("outs_per_frame", ACC_W'(frame_out), ACC_W'(NOUT));
      frame_out = 0;
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [IFM_W-1:0] p, input logic [WGT_W-1:0] w);
    logic             ev;
    logic [ACC_W-1:0] eo;
    logic             ed;
    int               r;
    int               c;
    in_valid = v;
    in_ifm   = p;
    in_wgt   = w;
    @(posedge clk);
    #1;
    ev = 1'b0;
    eo = '0;
    ed = 1'b0;
    if (v) begin
      r = idx / IMG_W;
      c = idx % IMG_W;
      pix[r][c] = p;
      if (idx < 9) wts[idx] = w;
      if (r >= 2 && c >= 2) begin
        ev = 1'b1;
        eo = refConv(r, c);
      end
      ed  = (idx == NPIX - 1);
      idx = ed ? 0 : idx + 1;
    end
    checkOutput(ev, eo, ed, idx != 0);
    cyc++;
  endtask

  task automatic doReset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_ifm   = IFM_W'($urandom);
    in_wgt   = WGT_W'($urandom);
    @(posedge clk);
    #1;
    check("rst_out_valid", ACC_W'(out_valid), '0);
    check("rst_Out_OFM", out_ofm, '0);
    check("rst_frame_done", ACC_W'(frame_done), '0);
    check("rst_busy", ACC_W'(busy), '0);
    rst       = 1'b0;
    in_valid  = 1'b0;
    idx       = 0;
    frame_out = 0;
  endtask

  // mode 0: ones; 1: pixel=index, centre tap only; 2: ones, weights 2; 3: extreme values; 4: random
  task automatic runFrame(input int mode, input int gap, input int nbeats);
    int               b = 0;
    logic [IFM_W-1:0] p;
    logic [WGT_W-1:0] w;
    while (b < nbeats) begin
      if (gap > 0 && (cyc % gap) == gap - 1) begin
        applyStimulus(1'b0, IFM_W'($urandom), WGT_W'($urandom));
      end else begin
        p = IFM_W'($urandom);
        w = WGT_W'($urandom);
        case (mode)
          0: begin p = 1; if (b < 9) w = 1; end
          1: begin p = IFM_W'(b); if (b < 9) w = (b == 4) ? 1 : 0; end
          2: begin p = 1; if (b < 9) w = 2; end
          3: begin
            p = '1;
`ifdef CONV_SIGNED_EN
            if (b < 9) w = 2;
`else
            if (b < 9) w = '1;
`endif
          end
          default: ;
        endcase
        applyStimulus(1'b1, p, w);
        b++;
      end
    end
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_ifm   = '0;
    in_wgt   = '0;
    doReset();

    $display("[TB] test 1: all ones");
    runFrame(0, 0, NPIX);

    $display("[TB] test 2: pixel index, centre tap");
    runFrame(1, 0, NPIX);
    check("t2_first", first_out, ACC_W'(15));
    check("t2_last", last_out, ACC_W'(180));

    $display("[TB] test 3: ones with stalls");
    cyc = 0;
    runFrame(0, 3, NPIX);

    $display("[TB] test 4: back-to-back frames");
    runFrame(0, 0, NPIX);
    runFrame(2, 0, NPIX);

    $display("[TB] test 5: reset mid-frame");
    runFrame(1, 0, 100);
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, IFM_W'($urandom), WGT_W'($urandom));
    runFrame(1, 0, NPIX);
    check("t5_first", first_out, ACC_W'(15));
    check("t5_last", last_out, ACC_W'(180));

    $display("[TB] test 6: extreme operands");
    runFrame(3, 0, NPIX);

    $display("[TB] random frames");
    cyc = 0;
    runFrame(4, 4, NPIX);
    runFrame(4, 0, NPIX);
    cyc = 1;
    runFrame(4, 5, NPIX);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, IFM_W'($urandom), WGT_W'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
